tc_tile_sched: RTL and testbench
================================

Name: tc_tile_sched

Overview:
- Tile-loop scheduler for the tensor-core partial-sum path.
- Walks the (m,k,n) tile space of an M×K×N GEMM and issues one tile command per handshake to the MAC array.
- Tags each outstanding command in an in-order FIFO and, as MAC results return, drives the psum accumulator's enable, add-valid and row/col pointers.
- After all tiles complete, waits for the accumulator's finish flag and pulses done.

Parameters:
- M, 16, rows of output matrix.
- K, 16, reduction depth.
- N, 16, columns of output matrix.
- M_TILE, 4, tile rows. K_TILE, 4, tile depth. N_TILE, 4, tile cols.
- DW_INT, 32, width of all index/pointer ports.
- OUTSTANDING, 4, max commands in flight (tag FIFO depth, ≥1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job start; ignored unless idle.
- cmd_valid  out  1  tile command valid to MAC array.
- cmd_ready  in  1  MAC array accepts command.
- cmd_m, cmd_k, cmd_n  out  DW_INT each  tile indices of the current command.
- res_valid  in  1  MAC tile result present this cycle (in-order, no backpressure).
- psum_enable  out  1  accumulator enable.
- psum_add_valid  out  1  accumulator add strobe.
- psum_ptr_row, psum_ptr_col  out  DW_INT each  accumulator tile pointers.
- psum_out_flag  in  2  accumulator status (2'b11 = finish).
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- err_overflow  out  1  sticky: res_valid seen with empty tag FIFO.

Behaviour:
- Iteration counts: IM=ceil(M/M_TILE), IK=ceil(K/K_TILE), IN=ceil(N/N_TILE), computed as (X+T-1)/T at elaboration. Total tiles T=IM·IK·IN.
- Reset (async, reset_n low), any time including mid-job:
  - state=IDLE; all counters zero; FIFO empty.
  - All outputs 0 except psum_ptr_col=all-ones sentinel.
  - No partial-state recovery.
- States: IDLE, ISSUE, WAIT_RET, DRAIN, DONE.
- IDLE:
  - start=1 → ISSUE next cycle, tile counters cleared, err_overflow cleared.
  - busy=0.
- ISSUE:
  - cmd_valid = (FIFO not full), combinational from registered state; cmd_m/k/n = current counters.
  - On cmd_valid&&cmd_ready: push {m,n} to FIFO; advance n; on n wrap advance k; on k wrap advance m. Loop order: m outer, k middle, n inner.
  - Handshake of the last tile (IM-1,IK-1,IN-1) → WAIT_RET.
  - cmd_valid must not drop once asserted until accepted, unless the FIFO is full.
  - A push is blocked when full, even if a pop occurs in the same cycle.
- Result path, any non-IDLE state:
  - psum_add_valid = res_valid && FIFO not empty.
  - psum_ptr_row/col = FIFO head when add_valid, else psum_ptr_col = all-ones sentinel, so the accumulator's column-count match cannot fire on idle cycles. Zero-cycle latency.
  - Pop on add_valid. Push and pop in the same cycle leave the count unchanged.
  - res_valid with empty FIFO: set err_overflow; no pop; no add_valid.
- WAIT_RET: FIFO empty and all T tiles issued → DRAIN.
- psum_enable = busy (high in ISSUE, WAIT_RET, DRAIN).
- DRAIN: psum_out_flag==2'b11 → DONE. No timeout.
- DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- busy=1 in ISSUE, WAIT_RET and DRAIN.
- start while busy: ignored, no effect.
- start in the DONE cycle: ignored.
- Degenerate case T=1: single handshake goes ISSUE → WAIT_RET directly.

Decomposition:
- Shared package tc_pkg:
  - state enum encoding (IDLE=0, ISSUE=1, WAIT_RET=2, DRAIN=3, DONE=4, 3-bit).
  - PSUM_FINISH=2'b11 and PSUM_VALID=2'b01 flag constants.
  - ceil-division function.
  - PTR_SENTINEL constant.
- Sub-module tc_sched_tag_fifo: synchronous FIFO, width 2·DW_INT, depth OUTSTANDING, with full/empty/count and async active-low reset.
- Scheduler FSM and counters stay in tc_tile_sched.

Test Plan:
- M=K=N=8, tiles 4, cmd_ready=1, res_valid 2 cycles after each handshake → commands in order (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0),(1,0,1),(1,1,0),(1,1,1); psum ptrs follow the same (m,n) order; 8 add_valid pulses.
- Finish flag: hold psum_out_flag=2'b11 five cycles after the last result → one done pulse; busy falls the same cycle done rises.
- Backpressure: OUTSTANDING=2, cmd_ready=1, withhold res_valid → exactly 2 handshakes, then cmd_valid=0. One res_valid → cmd_valid reasserts next cycle and the FIFO count stays at or below 2.
- Spurious result: res_valid while idle/empty → err_overflow=1, psum_add_valid=0. Next start clears it.
- Reset mid-ISSUE after 3 handshakes: reset_n low 1 cycle → all outputs 0 and ptr_col=all-ones immediately. New start restarts at (0,0,0).
- Defaults 16/4, random cmd_ready (50%) → exactly 64 handshakes and 64 add_valid pulses; no psum_add_valid without a matching res_valid.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types and constants for the tensor-core tile scheduler.
// Holds the state encoding, psum flag codes, pointer sentinel and ceil-division helper.
package tc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RET = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } tc_state_e;

  localparam logic [1:0] PSUM_FINISH = 2'b11;
  localparam logic [1:0] PSUM_VALID  = 2'b01;

  // Wide enough for any pointer width up to 64; consumers slice to their width.
  localparam logic [63:0] PTR_SENTINEL = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic int unsigned ceil_div(input int unsigned x, input int unsigned t);
    return (x + t - 32'd1) / t;
  endfunction

endpackage

// File: rtl/tc_sched_tag_fifo.sv
// In-order tag FIFO holding the {m,n} tile tag of every outstanding command.
// Push is ignored when full and pop when empty, so callers may strobe freely.
module tc_sched_tag_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_data,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return {AW{1'b0}};
    else return p + AW'(1);
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage array; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tc_tile_sched.sv
// Tile-loop scheduler: walks the (m,k,n) tile space, issues MAC commands, tags them
// in an in-order FIFO and steers the psum accumulator as results return.
module tc_tile_sched
  import tc_pkg::*;
#(
  parameter int M           = 16,
  parameter int K           = 16,
  parameter int N           = 16,
  parameter int M_TILE      = 4,
  parameter int K_TILE      = 4,
  parameter int N_TILE      = 4,
  parameter int DW_INT      = 32,
  parameter int OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [DW_INT-1:0] cmd_m,
  output logic [DW_INT-1:0] cmd_k,
  output logic [DW_INT-1:0] cmd_n,
  input  logic              res_valid,
  output logic              psum_enable,
  output logic              psum_add_valid,
  output logic [DW_INT-1:0] psum_ptr_row,
  output logic [DW_INT-1:0] psum_ptr_col,
  input  logic [1:0]        psum_out_flag,
  output logic              busy,
  output logic              done,
  output logic              err_overflow
);

  localparam int unsigned IM = ceil_div(M, M_TILE);
  localparam int unsigned IK = ceil_div(K, K_TILE);
  localparam int unsigned IN = ceil_div(N, N_TILE);
  localparam logic [DW_INT-1:0] IM_LAST = DW_INT'(IM - 1);
  localparam logic [DW_INT-1:0] IK_LAST = DW_INT'(IK - 1);
  localparam logic [DW_INT-1:0] IN_LAST = DW_INT'(IN - 1);
  localparam logic [DW_INT-1:0] SENT    = PTR_SENTINEL[DW_INT-1:0];
  localparam int FW = 2 * DW_INT;
  localparam int CW = $clog2(OUTSTANDING + 1);

  tc_state_e         r_state;
  logic [DW_INT-1:0] r_m;
  logic [DW_INT-1:0] r_k;
  logic [DW_INT-1:0] r_n;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [FW-1:0]     w_head;
  logic              w_cmd_valid;
  logic              w_push;
  logic              w_add_valid;
  logic              w_last;

  assign w_cmd_valid = (r_state == ST_ISSUE) && !w_full;
  assign w_push      = w_cmd_valid && cmd_ready;
  assign w_add_valid = res_valid && !w_empty;
  assign w_last      = (r_m == IM_LAST) && (r_k == IK_LAST) && (r_n == IN_LAST);

  tc_sched_tag_fifo #(
    .W     (FW),
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  ({r_m, r_n}),
    .i_pop   (w_add_valid),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign cmd_valid      = w_cmd_valid;
  assign cmd_m          = r_m;
  assign cmd_k          = r_k;
  assign cmd_n          = r_n;
  assign psum_enable    = r_busy;
  assign psum_add_valid = w_add_valid;
  assign psum_ptr_row   = w_add_valid ? w_head[FW-1:DW_INT] : {DW_INT{1'b0}};
  // Sentinel keeps the accumulator's column match from firing on idle cycles.
  assign psum_ptr_col   = w_add_valid ? w_head[DW_INT-1:0] : SENT;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_overflow   = r_err;

  // Scheduler FSM, tile counters and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_m     <= {DW_INT{1'b0}};
      r_k     <= {DW_INT{1'b0}};
      r_n     <= {DW_INT{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (res_valid && w_empty) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ISSUE;
            r_m     <= {DW_INT{1'b0}};
            r_k     <= {DW_INT{1'b0}};
            r_n     <= {DW_INT{1'b0}};
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (w_push) begin
            if (r_n == IN_LAST) begin
              r_n <= {DW_INT{1'b0}};
              if (r_k == IK_LAST) begin
                r_k <= {DW_INT{1'b0}};
                if (r_m == IM_LAST) r_m <= {DW_INT{1'b0}};
                else r_m <= r_m + DW_INT'(1);
              end else begin
                r_k <= r_k + DW_INT'(1);
              end
            end else begin
              r_n <= r_n + DW_INT'(1);
            end
            if (w_last) r_state <= ST_WAIT_RET;
          end
        end
        // Only reachable after the final handshake, so an empty FIFO means all tiles returned.
        ST_WAIT_RET: begin
          if (w_count == {CW{1'b0}}) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (psum_out_flag == PSUM_FINISH) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_tile_sched.sv
// Directed bench for tc_tile_sched: an 8x8x8 instance with two outstanding tags and a
// default 16x16x16 instance driven with random command backpressure.
module tb_tc_tile_sched;

  localparam int DW = 32;
  localparam logic [63:0] SENT = 64'h0000_0000_FFFF_FFFF;

  logic clk;
  int   n_checks = 0;
  int   n_errors = 0;

  logic          a_rst_n, a_start, a_cmd_ready, a_res_valid;
  logic [1:0]    a_flag;
  logic          a_cmd_valid, a_psum_enable, a_add_valid, a_busy, a_done, a_err;
  logic [DW-1:0] a_cmd_m, a_cmd_k, a_cmd_n, a_ptr_row, a_ptr_col;

  logic          b_rst_n, b_start, b_cmd_ready, b_res_valid;
  logic [1:0]    b_flag;
  logic          b_cmd_valid, b_psum_enable, b_add_valid, b_busy, b_done, b_err;
  logic [DW-1:0] b_cmd_m, b_cmd_k, b_cmd_n, b_ptr_row, b_ptr_col;

  tc_tile_sched #(.M(8), .K(8), .N(8), .OUTSTANDING(2)) u_dut_a (
    .clk(clk), .reset_n(a_rst_n), .start(a_start),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_m(a_cmd_m), .cmd_k(a_cmd_k), .cmd_n(a_cmd_n),
    .res_valid(a_res_valid), .psum_enable(a_psum_enable), .psum_add_valid(a_add_valid),
    .psum_ptr_row(a_ptr_row), .psum_ptr_col(a_ptr_col), .psum_out_flag(a_flag),
    .busy(a_busy), .done(a_done), .err_overflow(a_err)
  );

  tc_tile_sched u_dut_b (
    .clk(clk), .reset_n(b_rst_n), .start(b_start),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_m(b_cmd_m), .cmd_k(b_cmd_k), .cmd_n(b_cmd_n),
    .res_valid(b_res_valid), .psum_enable(b_psum_enable), .psum_add_valid(b_add_valid),
    .psum_ptr_row(b_ptr_row), .psum_ptr_col(b_ptr_col), .psum_out_flag(b_flag),
    .busy(b_busy), .done(b_done), .err_overflow(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int exp_m [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int exp_k [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
  int exp_n [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    int hs_cnt, add_cnt, done_cnt, since_last, bad_cmd, bad_ptr, orphan;
    logic hs, d1, d2;
    int mm, kk, nn;
    logic [63:0] q[$];
    logic [63:0] tag;

    a_rst_n = 1'b0; a_start = 1'b0; a_cmd_ready = 1'b0; a_res_valid = 1'b0; a_flag = 2'b00;
    b_rst_n = 1'b0; b_start = 1'b0; b_cmd_ready = 1'b0; b_res_valid = 1'b0; b_flag = 2'b00;
    #2;
    chk("rst_a_cmd_valid", a_cmd_valid, 64'd0);
    chk("rst_a_busy", a_busy, 64'd0);
    chk("rst_a_enable", a_psum_enable, 64'd0);
    chk("rst_a_done", a_done, 64'd0);
    chk("rst_a_ptr_row", a_ptr_row, 64'd0);
    chk("rst_a_ptr_col", a_ptr_col, SENT);
    chk("rst_b_ptr_col", b_ptr_col, SENT);
    chk("rst_b_cmd_m", b_cmd_m, 64'd0);
    @(negedge clk); a_rst_n = 1'b1; b_rst_n = 1'b1;

    // Test 1: full 8-tile job, results two cycles after each handshake.
    @(negedge clk); a_start = 1'b1; a_cmd_ready = 1'b1;
    @(negedge clk); a_start = 1'b0;
    hs_cnt = 0; add_cnt = 0; done_cnt = 0; since_last = 0; d1 = 1'b0; d2 = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc != 0) @(negedge clk);
      a_res_valid = d2;
      a_flag = (add_cnt == 8 && since_last >= 5) ? 2'b11 : 2'b00;
      #1;
      hs = a_cmd_valid && a_cmd_ready;
      if (hs && hs_cnt < 8) begin
        chk("t1_cmd_m", a_cmd_m, 64'(exp_m[hs_cnt]));
        chk("t1_cmd_k", a_cmd_k, 64'(exp_k[hs_cnt]));
        chk("t1_cmd_n", a_cmd_n, 64'(exp_n[hs_cnt]));
      end
      if (hs) hs_cnt++;
      if (a_add_valid) begin
        if (add_cnt < 8) begin
          chk("t1_ptr_row", a_ptr_row, 64'(exp_m[add_cnt]));
          chk("t1_ptr_col", a_ptr_col, 64'(exp_n[add_cnt]));
        end
        add_cnt++;
        since_last = 0;
      end else begin
        since_last++;
      end
      if (a_done) begin
        done_cnt++;
        chk("t1_busy_at_done", a_busy, 64'd0);
      end
      d2 = d1; d1 = hs;
      if (done_cnt != 0) break;
    end
    chk("t1_handshakes", hs_cnt, 64'd8);
    chk("t1_add_pulses", add_cnt, 64'd8);
    chk("t1_done_pulses", done_cnt, 64'd1);
    @(negedge clk); a_flag = 2'b00; a_res_valid = 1'b0; #1;
    chk("t1_done_one_cycle", a_done, 64'd0);
    chk("t1_idle_col_sentinel", a_ptr_col, SENT);
    chk("t1_err_clean", a_err, 64'd0);

    // Test 2: backpressure with two tag slots and results withheld.
    @(negedge clk); a_start = 1'b1; a_cmd_ready = 1'b1; a_res_valid = 1'b0;
    @(negedge clk); a_start = 1'b0;
    hs_cnt = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc != 0) @(negedge clk);
      #1;
      if (a_cmd_valid && a_cmd_ready) hs_cnt++;
    end
    chk("t2_handshakes_full", hs_cnt, 64'd2);
    chk("t2_cmd_valid_full", a_cmd_valid, 64'd0);
    @(negedge clk); a_res_valid = 1'b1; #1;
    chk("t2_add_valid", a_add_valid, 64'd1);
    chk("t2_ptr_row", a_ptr_row, 64'd0);
    chk("t2_ptr_col", a_ptr_col, 64'd0);
    chk("t2_push_blocked_on_pop", a_cmd_valid, 64'd0);
    @(negedge clk); a_res_valid = 1'b0; #1;
    chk("t2_cmd_valid_reassert", a_cmd_valid, 64'd1);
    chk("t2_cmd_m", a_cmd_m, 64'd0);
    chk("t2_cmd_k", a_cmd_k, 64'd1);
    chk("t2_cmd_n", a_cmd_n, 64'd0);
    @(negedge clk); #1;
    chk("t2_full_again", a_cmd_valid, 64'd0);

    // Test 3: reset mid-ISSUE after three handshakes.
    @(negedge clk); a_rst_n = 1'b0; #1;
    chk("t3_cmd_valid", a_cmd_valid, 64'd0);
    chk("t3_busy", a_busy, 64'd0);
    chk("t3_enable", a_psum_enable, 64'd0);
    chk("t3_cmd_k", a_cmd_k, 64'd0);
    chk("t3_ptr_row", a_ptr_row, 64'd0);
    chk("t3_ptr_col", a_ptr_col, SENT);
    @(negedge clk); a_rst_n = 1'b1;
    @(negedge clk); a_start = 1'b1; a_cmd_ready = 1'b0;
    @(negedge clk); a_start = 1'b0; #1;
    chk("t3_restart_valid", a_cmd_valid, 64'd1);
    chk("t3_restart_busy", a_busy, 64'd1);
    chk("t3_restart_m", a_cmd_m, 64'd0);
    chk("t3_restart_k", a_cmd_k, 64'd0);
    chk("t3_restart_n", a_cmd_n, 64'd0);
    @(negedge clk); a_rst_n = 1'b0;
    @(negedge clk); a_rst_n = 1'b1;

    // Test 4: spurious result while idle.
    @(negedge clk); a_res_valid = 1'b1; #1;
    chk("t4_no_add_valid", a_add_valid, 64'd0);
    chk("t4_col_sentinel", a_ptr_col, SENT);
    @(negedge clk); a_res_valid = 1'b0; #1;
    chk("t4_err_set", a_err, 64'd1);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0; #1;
    chk("t4_err_cleared", a_err, 64'd0);
    @(negedge clk); a_rst_n = 1'b0;
    @(negedge clk); a_rst_n = 1'b1;

    // Test 5: default 64-tile job, random command backpressure.
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    hs_cnt = 0; add_cnt = 0; done_cnt = 0; since_last = 0; d1 = 1'b0; d2 = 1'b0;
    bad_cmd = 0; bad_ptr = 0; orphan = 0; mm = 0; kk = 0; nn = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      b_res_valid = d2;
      b_cmd_ready = 1'($urandom_range(0, 1));
      b_flag = (add_cnt == 64 && since_last >= 5) ? 2'b11 : 2'b00;
      #1;
      hs = b_cmd_valid && b_cmd_ready;
      if (hs) begin
        if (b_cmd_m != DW'(mm) || b_cmd_k != DW'(kk) || b_cmd_n != DW'(nn)) bad_cmd++;
        q.push_back({32'(mm), 32'(nn)});
        hs_cnt++;
        nn++;
        if (nn == 4) begin
          nn = 0; kk++;
          if (kk == 4) begin kk = 0; mm++; end
        end
      end
      if (b_add_valid) begin
        if (!b_res_valid) orphan++;
        if (q.size() == 0) begin
          bad_ptr++;
        end else begin
          tag = q.pop_front();
          if ({b_ptr_row, b_ptr_col} != tag) bad_ptr++;
        end
        add_cnt++;
        since_last = 0;
      end else begin
        since_last++;
      end
      if (b_done) done_cnt++;
      d2 = d1; d1 = hs;
      if (done_cnt != 0) break;
    end
    chk("t5_handshakes", hs_cnt, 64'd64);
    chk("t5_add_pulses", add_cnt, 64'd64);
    chk("t5_cmd_order_errs", bad_cmd, 64'd0);
    chk("t5_ptr_errs", bad_ptr, 64'd0);
    chk("t5_orphan_adds", orphan, 64'd0);
    chk("t5_done_pulses", done_cnt, 64'd1);
    chk("t5_err", b_err, 64'd0);
    @(negedge clk); b_flag = 2'b00; #1;
    chk("t5_idle_busy", b_busy, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
